// File: rtl/seg_pkg.sv
// Shared constants, the hex-to-segment table and the control record
// for the multiplexed seven-segment scan driver.
package seg_pkg;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [7:0] AN_OFF     = 8'hFF;
  localparam int         MAX_DIGITS = 8;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [2:0] bright;
    logic       lzSup;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{bright: 3'd7, lzSup: 1'b0};

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decoder; point_i=1 lights the decimal point.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       point_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = {~point_i, HEX_TABLE[nibble_i]};
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with double-buffered data,
// blink, leading-zero suppression and PWM brightness.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 131072,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] hexs,
  input  logic [DIGITS-1:0]   points,
  input  logic [DIGITS-1:0]   blanks,
  input  logic [DIGITS-1:0]   blinks,
  input  logic [2:0]          bright,
  input  logic                lz_sup,
  input  logic                load,
  output logic                updated,
  output logic [DIGITS-1:0]   AN,
  output logic [7:0]          SEGMENT
);

  localparam int CNT_W     = $clog2(SCAN_DIV);
  localparam int DIG_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLK_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SLOT_STEP = SCAN_DIV / 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]    divCnt_q, divCnt_d;
  logic [DIG_W-1:0]    digit_q, digit_d;
  logic [BLK_W-1:0]    frameCnt_q, frameCnt_d;
  logic                phase_q, phase_d;
  logic                pendFlag_q, pendFlag_d;

  logic [4*DIGITS-1:0] pendHex_q, pendHex_d, shHex_q, shHex_d;
  logic [DIGITS-1:0]   pendPoints_q, pendPoints_d, shPoints_q, shPoints_d;
  logic [DIGITS-1:0]   pendBlanks_q, pendBlanks_d, shBlanks_q, shBlanks_d;
  logic [DIGITS-1:0]   pendBlinks_q, pendBlinks_d, shBlinks_q, shBlinks_d;
  ctrl_t               pendCtrl_q, pendCtrl_d, shCtrl_q, shCtrl_d;

  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;

  logic                slotEnd, frameEnd;
  logic [DIGITS-1:0]   suppressed;
  logic                zeroRun;
  logic [CNT_W:0]      onLimit;
  logic                pwmOn, lit;
  logic [3:0]          curNib;
  logic                curPoint;
  logic [7:0]          decSeg;

  always_comb begin
    slotEnd    = (divCnt_q == CNT_LAST);
    frameEnd   = slotEnd && (digit_q == DIG_LAST);
    divCnt_d   = slotEnd ? '0 : divCnt_q + 1'b1;
    digit_d    = digit_q;
    frameCnt_d = frameCnt_q;
    phase_d    = phase_q;
    if (slotEnd) begin
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
    end
    if (frameEnd) begin
      frameCnt_d = (frameCnt_q == BLK_LAST) ? '0 : frameCnt_q + 1'b1;
      phase_d    = (frameCnt_q == BLK_LAST) ? ~phase_q : phase_q;
    end
  end

  // Shadow only changes on a frame boundary, so a frame never mixes two loads
  always_comb begin
    pendHex_d    = pendHex_q;
    pendPoints_d = pendPoints_q;
    pendBlanks_d = pendBlanks_q;
    pendBlinks_d = pendBlinks_q;
    pendCtrl_d   = pendCtrl_q;
    pendFlag_d   = pendFlag_q;
    shHex_d      = shHex_q;
    shPoints_d   = shPoints_q;
    shBlanks_d   = shBlanks_q;
    shBlinks_d   = shBlinks_q;
    shCtrl_d     = shCtrl_q;
    if (frameEnd && pendFlag_q) begin
      shHex_d    = pendHex_q;
      shPoints_d = pendPoints_q;
      shBlanks_d = pendBlanks_q;
      shBlinks_d = pendBlinks_q;
      shCtrl_d   = pendCtrl_q;
      pendFlag_d = 1'b0;
    end
    if (load) begin
      pendHex_d    = hexs;
      pendPoints_d = points;
      pendBlanks_d = blanks;
      pendBlinks_d = blinks;
      pendCtrl_d   = '{bright: bright, lzSup: lz_sup};
      pendFlag_d   = 1'b1;
    end
  end

  assign updated = frameEnd && pendFlag_q;

  // Leading zeros are dark from the top digit down; digit 0 always shows
  always_comb begin
    suppressed = '0;
    zeroRun    = shCtrl_q.lzSup;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zeroRun       = zeroRun && (shHex_q[4*i +: 4] == 4'h0);
      suppressed[i] = zeroRun;
    end
  end

  assign onLimit  = (CNT_W+1)'((int'(shCtrl_q.bright) + 1) * SLOT_STEP);
  assign pwmOn    = ({1'b0, divCnt_q} < onLimit);
  assign curNib   = shHex_q[int'(digit_q)*4 +: 4];
  assign curPoint = shPoints_q[digit_q];

  seg_hex_decode u_dec (
    .nibble_i (curNib),
    .point_i  (curPoint),
    .seg_o    (decSeg)
  );

  always_comb begin
    lit   = !shBlanks_q[digit_q] && !(phase_q && shBlinks_q[digit_q])
            && !suppressed[digit_q] && pwmOn;
    an_d  = lit ? ~(DIGITS'(1) << digit_q) : AN_OFF[DIGITS-1:0];
    seg_d = lit ? decSeg : SEG_OFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divCnt_q     <= '0;
      digit_q      <= '0;
      frameCnt_q   <= '0;
      phase_q      <= 1'b0;
      pendFlag_q   <= 1'b0;
      pendHex_q    <= '0;
      pendPoints_q <= '0;
      pendBlanks_q <= '1;
      pendBlinks_q <= '0;
      pendCtrl_q   <= CTRL_RESET;
      shHex_q      <= '0;
      shPoints_q   <= '0;
      shBlanks_q   <= '1;
      shBlinks_q   <= '0;
      shCtrl_q     <= CTRL_RESET;
      an_q         <= AN_OFF[DIGITS-1:0];
      seg_q        <= SEG_OFF;
    end else begin
      divCnt_q     <= divCnt_d;
      digit_q      <= digit_d;
      frameCnt_q   <= frameCnt_d;
      phase_q      <= phase_d;
      pendFlag_q   <= pendFlag_d;
      pendHex_q    <= pendHex_d;
      pendPoints_q <= pendPoints_d;
      pendBlanks_q <= pendBlanks_d;
      pendBlinks_q <= pendBlinks_d;
      pendCtrl_q   <= pendCtrl_d;
      shHex_q      <= shHex_d;
      shPoints_q   <= shPoints_d;
      shBlanks_q   <= shBlanks_d;
      shBlinks_q   <= shBlinks_d;
      shCtrl_q     <= shCtrl_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign AN      = an_q;
  assign SEGMENT = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a cycle-count display model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_seg_scan_driver;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BLINK_FRAMES = 2;
  localparam int SLOT         = SCAN_DIV;
  localparam int FRAME        = SCAN_DIV * DIGITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] hexs = '0;
  logic [3:0]  points = '0;
  logic [3:0]  blanks = '0;
  logic [3:0]  blinks = '0;
  logic [2:0]  bright = '0;
  logic        lz_sup = 1'b0;
  logic        load = 1'b0;
  logic        updated;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;

  seg_scan_driver #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .hexs    (hexs),
    .points  (points),
    .blanks  (blanks),
    .blinks  (blinks),
    .bright  (bright),
    .lz_sup  (lz_sup),
    .load    (load),
    .updated (updated),
    .AN      (AN),
    .SEGMENT (SEGMENT)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  pts;
    logic [3:0]  blk;
    logic [3:0]  bln;
    logic [2:0]  br;
    logic        lz;
  } disp_t;

  localparam disp_t RESET_DISP = '{hex: 16'h0, pts: 4'h0, blk: 4'hF, bln: 4'h0, br: 3'd7, lz: 1'b0};

  // Active-low patterns including an unlit dp, digits 0..F
  localparam logic [7:0] SEGTAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  disp_t       mPend = RESET_DISP;
  disp_t       mSh = RESET_DISP;
  bit          mFlag = 1'b0;
  logic [3:0]  expAN = 4'hF;
  logic [7:0]  expSEG = 8'hFF;
  logic        expUpd = 1'b0;
  bit          checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // What cycle kk of the scan must show, derived from position in the frame
  function automatic logic [11:0] expectedOut(int kk, disp_t s);
    int pos, c, d, top;
    bit ph, dark;
    logic [3:0] nib;
    pos = kk % FRAME;
    c   = pos % SLOT;
    d   = pos / SLOT;
    ph  = (((kk / FRAME) / BLINK_FRAMES) % 2) == 1;
    top = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (s.hex[4*i +: 4] != 4'h0) top = i;
    end
    nib  = s.hex[4*d +: 4];
    dark = s.blk[d] || (ph && s.bln[d]) || (s.lz && d > top)
           || (c >= ((int'(s.br) + 1) * SCAN_DIV / 8));
    if (dark) return {4'hF, 8'hFF};
    return {~(4'b0001 << d), ~s.pts[d], SEGTAB[nib][6:0]};
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      k      = 0;
      mPend  = RESET_DISP;
      mSh    = RESET_DISP;
      mFlag  = 1'b0;
      expAN  = 4'hF;
      expSEG = 8'hFF;
      expUpd = 1'b0;
    end else begin
      {expAN, expSEG} = expectedOut(k, mSh);
      if ((k % FRAME) == FRAME - 1 && mFlag) begin
        mSh   = mPend;
        mFlag = 1'b0;
      end
      if (load) begin
        mPend = '{hex: hexs, pts: points, blk: blanks, bln: blinks, br: bright, lz: lz_sup};
        mFlag = 1'b1;
      end
      k++;
      expUpd = ((k % FRAME) == FRAME - 1) && mFlag;
    end
  end

  initial forever begin
    @(negedge clk);
    if (checkEn) begin
      checkOutput("model AN", AN, expAN);
      checkOutput("model SEGMENT", SEGMENT, expSEG);
      checkOutput("model updated", updated, expUpd);
      checkOutput("single anode", ($countones(~AN) <= 1), 1);
    end
  end

  task automatic applyStimulus(input logic [15:0] h, input logic [3:0] pt, input logic [3:0] bk,
                               input logic [3:0] bl, input logic [2:0] br, input logic lz);
    hexs   = h;
    points = pt;
    blanks = bk;
    blinks = bl;
    bright = br;
    lz_sup = lz;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic waitPos(input int p);
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(negedge clk);
      if ((k % FRAME) == p) return;
    end
    timeoutFail("waitPos");
  endtask

  task automatic waitUpdated();
    for (int n = 0; n < 3 * FRAME; n++) begin
      @(negedge clk);
      if (updated === 1'b1) return;
    end
    timeoutFail("waitUpdated");
  endtask

  task automatic countSamples(input int cycles, output int litCnt, output int updCnt);
    litCnt = 0;
    updCnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (AN !== 4'hF) litCnt++;
      if (updated === 1'b1) updCnt++;
    end
  endtask

  task automatic checkSlot(input string name, input logic [3:0] an, input logic [7:0] seg);
    checkOutput({name, " AN"}, AN, an);
    checkOutput({name, " SEGMENT"}, SEGMENT, seg);
  endtask

  initial begin
    int litCnt, updCnt;
    #3 rst = 1'b0;
    #1;
    checkSlot("in reset", 4'hF, 8'hFF);
    checkOutput("in reset updated", updated, 0);
    checkEn = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    $display("[TB] idle after reset");
    countSamples(3 * FRAME, litCnt, updCnt);
    checkOutput("idle lit samples", litCnt, 0);
    checkOutput("idle updated pulses", updCnt, 0);

    $display("[TB] basic load 12AF");
    applyStimulus(16'h12AF, 4'h0, 4'h0, 4'h0, 3'd7, 1'b0);
    waitUpdated();
    repeat (2) @(negedge clk);
    checkSlot("12AF digit0", 4'hE, 8'h8E);
    repeat (8) @(negedge clk);
    checkSlot("12AF digit1", 4'hD, 8'h88);
    repeat (8) @(negedge clk);
    checkSlot("12AF digit2", 4'hB, 8'hA4);
    repeat (8) @(negedge clk);
    checkSlot("12AF digit3", 4'h7, 8'hF9);

    $display("[TB] two loads in one frame");
    waitPos(2);
    applyStimulus(16'h1111, 4'h0, 4'h0, 4'h0, 3'd7, 1'b0);
    waitPos(10);
    applyStimulus(16'h2222, 4'h0, 4'h0, 4'h0, 3'd7, 1'b0);
    waitUpdated();
    repeat (2) @(negedge clk);
    checkSlot("2222 digit0", 4'hE, 8'hA4);
    countSamples(2 * FRAME, litCnt, updCnt);
    checkOutput("2222 lit samples", litCnt, 2 * FRAME);
    checkOutput("2222 extra updated", updCnt, 0);

    $display("[TB] load on frame boundary");
    waitPos(5);
    applyStimulus(16'h3333, 4'h0, 4'h0, 4'h0, 3'd7, 1'b0);
    waitPos(FRAME - 1);
    checkOutput("boundary updated", updated, 1);
    applyStimulus(16'h4444, 4'h0, 4'h0, 4'h0, 3'd7, 1'b0);
    @(negedge clk);
    checkSlot("3333 digit0", 4'hE, 8'hB0);
    waitUpdated();
    repeat (2) @(negedge clk);
    checkSlot("4444 digit0", 4'hE, 8'h99);

    $display("[TB] leading-zero suppression");
    applyStimulus(16'h0070, 4'h0, 4'h0, 4'h0, 3'd7, 1'b1);
    waitUpdated();
    repeat (2) @(negedge clk);
    checkSlot("0070 digit0", 4'hE, 8'hC0);
    repeat (8) @(negedge clk);
    checkSlot("0070 digit1", 4'hD, 8'hF8);
    repeat (8) @(negedge clk);
    checkSlot("0070 digit2", 4'hF, 8'hFF);
    repeat (8) @(negedge clk);
    checkSlot("0070 digit3", 4'hF, 8'hFF);
    applyStimulus(16'h0000, 4'h0, 4'h0, 4'h0, 3'd7, 1'b1);
    waitUpdated();
    repeat (2) @(negedge clk);
    checkSlot("0000 digit0", 4'hE, 8'hC0);
    repeat (8) @(negedge clk);
    checkSlot("0000 digit1", 4'hF, 8'hFF);

    $display("[TB] brightness and blink");
    applyStimulus(16'h1234, 4'h0, 4'h0, 4'h0, 3'd1, 1'b0);
    waitUpdated();
    @(negedge clk);
    countSamples(SLOT, litCnt, updCnt);
    checkOutput("bright1 lit per slot", litCnt, 2);
    applyStimulus(16'h1234, 4'h0, 4'h0, 4'b0001, 3'd7, 1'b0);
    waitUpdated();
    @(negedge clk);
    countSamples(4 * FRAME, litCnt, updCnt);
    checkOutput("blink lit samples", litCnt, 3 * 4 * SLOT + 2 * SLOT);

    $display("[TB] reset with pending load");
    waitPos(3);
    applyStimulus(16'h5555, 4'h0, 4'h0, 4'h0, 3'd7, 1'b0);
    waitPos(10);
    checkOutput("pre-reset AN lit", (AN != 4'hF), 1);
    #2 rst = 1'b0;
    #1;
    checkSlot("async reset", 4'hF, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    countSamples(2 * FRAME, litCnt, updCnt);
    checkOutput("post-reset lit samples", litCnt, 0);
    checkOutput("post-reset updated", updCnt, 0);

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
